// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR counter and its sample FIFO.
// Holds the default sample width, default FIFO depth, the stored entry
// layout {wrap, data} and the saturating helper for the drop counter.
package lfsr_pkg;

  // Count width of the upstream LFSR counter; the FIFO sample width follows it.
  localparam int unsigned LfsrWidth = 8;

  // Default number of FIFO entries (power of two, at least 2).
  localparam int unsigned FifoDepth = 4;

  // Width and ceiling of the rejected-push counter.
  localparam int unsigned DropCntWidth = 8;
  localparam logic [DropCntWidth-1:0] DropCntMax = {DropCntWidth{1'b1}};

  // One stored sample: overflow flag above the count bits.
  typedef struct packed {
    logic                 wrap;
    logic [LfsrWidth-1:0] data;
  } lfsr_entry_t;

  // Increment that sticks at the all-ones value.
  function automatic logic [DropCntWidth-1:0] sat_inc(input logic [DropCntWidth-1:0] value);
    logic [DropCntWidth-1:0] result;
    result = value;
    if (value != DropCntMax) begin
      result = value + DropCntWidth'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/lfsr_fifo_mem.sv
// Register-array storage for the LFSR sample FIFO.
// One synchronous write port and one asynchronous read port; contents are
// deliberately not reset, so validity is tracked entirely by the caller.
module lfsr_fifo_mem #(
  parameter int unsigned EntryWidth = 9,
  parameter int unsigned Depth      = 4,
  parameter int unsigned AddrWidth  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AddrWidth-1:0]  waddr_i,
  input  logic [EntryWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0]  raddr_i,
  output logic [EntryWidth-1:0] rdata_o
);

  logic [EntryWidth-1:0] mem_q [Depth];

  // Write the addressed entry on a qualified push.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read of the head entry.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/lfsr_sample_fifo.sv
// Sample FIFO behind the LFSR counter.
// Captures {in_overflow, in_data} on each accepted push and presents the
// oldest entry with valid/ready handshaking. Occupancy is held in a level
// counter and full/empty are derived from it, never from the pointers.
// Optional feature: define LFSR_FIFO_DROP_CNT_EN to build the saturating
// count of rejected pushes; otherwise drop_count is tied to zero.
module lfsr_sample_fifo
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = LfsrWidth,
  parameter int unsigned DEPTH = FifoDepth
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_wrap,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [DropCntWidth-1:0]  drop_count
);

  localparam int unsigned AddrW   = $clog2(DEPTH);
  localparam int unsigned LevelW  = AddrW + 1;
  localparam int unsigned EntryW  = WIDTH + 1;
  localparam logic [AddrW-1:0]  LastAddr = AddrW'(DEPTH - 1);
  localparam logic [LevelW-1:0] FullLvl  = LevelW'(DEPTH);

  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q,  level_d;

  logic              push;
  logic              pop;
  logic              drop;
  logic [EntryW-1:0] wr_entry;
  logic [EntryW-1:0] rd_entry;

  // Status derived from the occupancy counter.
  always_comb begin
    out_valid = (level_q != '0);
    full      = (level_q == FullLvl);
    level     = level_q;
  end

  // Handshake qualification; a full FIFO still takes a push when it pops.
  // Nothing is accepted while reset is held so the reset cycle stays inert.
  always_comb begin
    pop  = reset && out_valid && out_ready;
    push = reset && in_valid && (!full || pop);
    drop = reset && in_valid && full && !pop;
  end

  // Entry layout matches lfsr_entry_t: wrap flag in the top bit.
  always_comb begin
    wr_entry = {in_overflow, in_data};
  end

  // Storage: written at the write pointer, read combinationally at the head.
  lfsr_fifo_mem #(
    .EntryWidth (EntryW),
    .Depth      (DEPTH),
    .AddrWidth  (AddrW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Head entry unpacked onto the output ports.
  always_comb begin
    out_wrap = rd_entry[EntryW-1];
    out_data = rd_entry[WIDTH-1:0];
  end

  // Next-state for pointers (explicit wrap at the last slot) and level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + AddrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AddrW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

`ifdef LFSR_FIFO_DROP_CNT_EN
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter next-state.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // Drop counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;

  // Counter not built; the drop qualifier is intentionally left unused.
  always_comb begin
    unused_drop = drop;
  end

  assign drop_count = '0;
`endif

endmodule
